// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_responder.sv
// Data-port responder: stalls the core while one load/store runs over the
// SRAM req/ack handshake, then releases it for one cycle with the result.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WORDS = 16384,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        stall,
    output logic [31:0] core_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [32:0]   ADDR_LIMIT = 33'(ADDR_WORDS) << 2;
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT);

    dmem_state_t   state;
    logic [CW-1:0] cnt;
    logic [31:0]   result;
    logic          acc_ok;

    // 33-bit compare so a full 4 GiB limit cannot overflow.
    assign acc_ok     = ({1'b0, core_addr} < ADDR_LIMIT) && (core_addr[1:0] == 2'b00);
    assign stall      = (state == REQ) || ((state == IDLE) && core_req);
    assign core_rdata = result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            result    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        mem_addr  <= core_addr[31:2];
                        mem_wdata <= core_wdata;
                        mem_we    <= core_we;
                        if (acc_ok) begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            cnt     <= CW'(1);
                        end else begin
                            state  <= DONE;
                            result <= '0;
                            err    <= 1'b1;
                            if (!err) err_addr <= core_addr;
                        end
                    end
                end
                REQ: begin
                    // cnt holds the 1-based index of the current REQ cycle;
                    // an ack in the final cycle still takes priority.
                    if (mem_ack) begin
                        result  <= mem_we ? 32'd0 : mem_rdata;
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= DONE;
                    end else if (cnt >= CNT_MAX) begin
                        result  <= DMEM_TIMEOUT_DATA;
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        err     <= 1'b1;
                        if (!err) err_addr <= {mem_addr, 2'b00};
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: driver issues core accesses and pushes expectations,
// an SRAM model answers mem_req, a monitor checks each completion.
module tb_dmem_responder;

    localparam int T = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_addr;
        int          stalls;
        int          reqs;
        logic [29:0] maddr;
        logic        mwe;
        logic [31:0] mwdata;
    } exp_t;

    logic        clk = 0;
    logic        reset = 0;
    logic        core_req = 0;
    logic        core_we = 0;
    logic [31:0] core_addr = 0;
    logic [31:0] core_wdata = 0;
    logic        stall;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;
    logic        err;
    logic [31:0] err_addr;

    int n_chk = 0;
    int n_pass = 0;
    int ack_delay = 0;

    exp_t        sb[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] sram    [logic [29:0]];
    logic        m_err = 0;
    logic [31:0] m_err_addr = 0;

    dmem_responder #(.ADDR_WORDS(16384), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .stall(stall), .core_rdata(core_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic preload(input logic [29:0] w, input logic [31:0] d);
        ref_mem[w] = d;
        sram[w]    = d;
    endtask

    // SRAM model: ack in the dly-th cycle of mem_req (dly outside 1..T never
    // acks), plus occasional stray acks while idle that must be ignored.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(negedge clk);
            mem_ack   = 0;
            mem_rdata = $urandom;
            if (mem_req && reset) begin
                rc++;
                if (rc == ack_delay) begin
                    mem_ack = 1;
                    if (mem_we) sram[mem_addr] = mem_wdata;
                    else mem_rdata = sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr);
                end
            end else begin
                rc = 0;
                if ($urandom_range(0, 7) == 0) mem_ack = 1;
            end
        end
    end

    // Monitor: a completion is the cycle the core is released with core_req high.
    initial begin
        int st, rq;
        logic [29:0] sa;
        logic sw;
        logic [31:0] sd;
        exp_t e;
        st = 0; rq = 0; sa = 0; sw = 0; sd = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                st = 0; rq = 0;
            end else begin
                if (stall) st++;
                if (mem_req) begin
                    rq++; sa = mem_addr; sw = mem_we; sd = mem_wdata;
                end
                if (core_req && !stall) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("core_rdata", core_rdata, e.rdata);
                        chk("err", {31'd0, err}, {31'd0, e.err});
                        chk("err_addr", err_addr, e.err_addr);
                        chk("stall_cycles", st, e.stalls);
                        chk("mem_req_cycles", rq, e.reqs);
                        if (e.reqs > 0) begin
                            chk("mem_addr", {2'b00, sa}, {2'b00, e.maddr});
                            chk("mem_we", {31'd0, sw}, {31'd0, e.mwe});
                            if (e.mwe) chk("mem_wdata", sd, e.mwdata);
                        end
                    end
                    st = 0; rq = 0;
                end
            end
        end
    end

    // Reference: plain address/delay rules, independent of the RTL's state machine.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input int gap);
        exp_t e;
        logic [29:0] w;
        bit ok, done;
        w  = addr[31:2];
        ok = (addr < 32'h0001_0000) && (addr[1:0] == 2'b00);
        e.maddr = w; e.mwe = we; e.mwdata = wd;
        if (!ok) begin
            e.rdata = 0; e.stalls = 1; e.reqs = 0;
            if (!m_err) m_err_addr = addr;
            m_err = 1;
        end else if (dly >= 1 && dly <= T) begin
            e.stalls = dly + 1; e.reqs = dly;
            if (we) begin
                e.rdata = 0; ref_mem[w] = wd;
            end else begin
                e.rdata = ref_mem.exists(w) ? ref_mem[w] : dflt(w);
            end
        end else begin
            e.stalls = T + 1; e.reqs = T; e.rdata = 32'hDEADBEEF;
            if (!m_err) m_err_addr = addr;
            m_err = 1;
        end
        e.err = m_err; e.err_addr = m_err_addr;

        @(posedge clk); #1;
        core_req = 1; core_we = we; core_addr = addr; core_wdata = wd; ack_delay = dly;
        sb.push_back(e);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1;
        end
        if (!done) chk("done_wait", 0, 1);
        if (gap > 0) begin
            @(posedge clk); #1;
            core_req = 0;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int r;
        #1;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {2'b00, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_addr", err_addr, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;

        preload(30'h4, 32'h12345678);
        access(0, 32'h10, 0, 3, 1);
        access(1, 32'h20, 32'hCAFEBABE, 1, 2);
        access(0, 32'h20, 0, 2, 0);
        access(0, 32'h0000_FFFC, 0, 2, 1);
        access(0, 32'h30, 0, 4, 1);
        access(0, 32'h40, 0, 0, 1);

        // Reset in the second REQ cycle of a never-acked load.
        @(posedge clk); #1;
        core_req = 1; core_we = 0; core_addr = 32'h80; ack_delay = 0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_rst_mem_req", {31'd0, mem_req}, 1);
        reset = 0; core_req = 0;
        #1;
        chk("async_mem_req", {31'd0, mem_req}, 0);
        chk("async_stall", {31'd0, stall}, 0);
        chk("async_err", {31'd0, err}, 0);
        chk("async_err_addr", err_addr, 0);
        chk("async_core_rdata", core_rdata, 0);
        m_err = 0; m_err_addr = 0;
        @(posedge clk); #1 reset = 1;

        access(0, 32'h10, 0, 2, 1);
        access(0, 32'h0001_0000, 0, 0, 1);
        access(0, 32'h6, 0, 0, 1);
        access(1, 32'h44, 32'h0BADF00D, 3, 0);
        access(0, 32'h44, 0, 1, 1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = $urandom;
                if (a < 32'h0001_0000) a = a | 32'h0001_0000;
            end else if (r == 1) begin
                a = ($urandom & 32'h0000_FFFC) | $urandom_range(1, 3);
            end else if (r == 2) begin
                a = 32'h0000_FFFC;
            end else begin
                a = $urandom_range(0, 31) << 2;
            end
            access($urandom_range(0, 1), a, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
        end

        @(posedge clk); #1 core_req = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the single-cycle MIPS core's data port. Accepts one load/store request at a time from the core, holds the core via `stall` while the access runs on a req/ack SRAM handshake, and returns load data in the cycle the core is released. Sits between the core's data-memory outputs and the external data SRAM. Flags out-of-range, misaligned and timed-out accesses.

## Interface
Parameters:
- `ADDR_WORDS`, 16384: data words implemented; valid byte addresses are 0 .. 4*ADDR_WORDS-1.
- `TIMEOUT`, 255: maximum cycles spent in REQ waiting for `mem_ack`, range 1..65535.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `core_req`  in  1  core is executing lw/sw this cycle; driven from the ungated instruction word and independent of `stall`.
- `core_we`  in  1  1 = sw, 0 = lw; valid when `core_req`.
- `core_addr`  in  32  byte address (ALU result).
- `core_wdata`  in  32  store data.
- `stall`  out  1  hold PC and squash the instruction.
- `core_rdata`  out  32  load data to the core's writeback mux.
- `mem_req`  out  1  SRAM request, held until ack.
- `mem_we`  out  1  SRAM write strobe, qualified by `mem_req`.
- `mem_addr`  out  30  word address (`core_addr[31:2]`, captured).
- `mem_wdata`  out  32  captured store data.
- `mem_ack`  in  1  SRAM completion, one-cycle pulse.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `err`  out  1  sticky error flag.
- `err_addr`  out  32  byte address of the first failing access.

## Operation
- States IDLE, REQ, DONE.
- IDLE: when `core_req`=1, `stall`=1 combinationally. Capture addr, wdata, we.
  - Address in range and `core_addr[1:0]`=0: go to REQ.
  - Otherwise: go to DONE with result 0. Set `err`, and load `err_addr` if `err` was 0.
- REQ: `stall`=1. `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable.
  - On `mem_ack`: latch `mem_rdata` (lw) or 0 (sw) into the result register, go to DONE.
  - Cycle counter reaches TIMEOUT without ack: drop `mem_req`, result = 32'hDEADBEEF, set `err`/`err_addr`, go to DONE.
- DONE: `stall`=0 and `core_rdata`=result. The core re-executes and completes the access this cycle. `core_req` is ignored, so the access is not relaunched. Go to IDLE unconditionally.
- `core_rdata` holds the last result outside DONE.
- `err` and `err_addr` clear only on reset.

## Timing
- Reset values: state IDLE; `stall` 0 (unless IDLE with `core_req`), `core_rdata` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `err` 0, `err_addr` 0, counter 0.
- Request seen in cycle 0:
  - `mem_req` high from cycle 1.
  - `mem_ack` in cycle k≥1 gives DONE in cycle k+1.
  - `stall` is high in cycles 0..k, so minimum stall is 2 cycles.
- Error access: stall in cycle 0 only, DONE in cycle 1.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, DONE on the next cycle.
- `mem_ack` in the same cycle the counter hits TIMEOUT: ack wins, no error.
- `mem_ack` outside REQ is ignored.
- Back-to-back accesses: the next request can be accepted in the IDLE cycle after DONE.
- Reset asserted mid-REQ: `mem_req` drops immediately (async), no result is delivered, and `err` clears.
- Counter width is `$clog2(TIMEOUT+1)` and the counter saturates, never wraps.

## Structure
- Package `dmem_pkg`: state enum `dmem_state_t` (IDLE, REQ, DONE) and constant `DMEM_TIMEOUT_DATA` = 32'hDEADBEEF.
- Single module, no sub-module. The counter and error capture are inline.

## Test plan
- lw to 0x10, ack 3 cycles after `mem_req`, `mem_rdata`=0x12345678 -> `stall` high 4 cycles, `mem_addr`=0x4, DONE with `core_rdata`=0x12345678, no relaunch in DONE.
- sw 0xCAFEBABE to 0x20, ack in cycle 1 -> `mem_we`=1, `mem_wdata`=0xCAFEBABE, stall exactly 2 cycles, `core_rdata`=0.
- lw to 0x0001_0000 (out of range), then lw to 0x6 (misaligned) -> no `mem_req`, 1-cycle stall each, `err`=1, `err_addr`=0x0001_0000 retained.
- TIMEOUT=4, never ack -> `mem_req` high 4 cycles, `core_rdata`=0xDEADBEEF, `err`=1. Repeat with ack in the 4th cycle -> normal completion, no error.
- Reset pulled low in the second REQ cycle -> `mem_req`/`stall` drop immediately. A new request after release is served normally.
